a2d_scan_avg: RTL and testbench

A2D_SCAN_AVG -- requirements
Module: a2d_scan_avg

---
 rtl/a2d_pkg.sv | 34 +++
 rtl/a2d_nxt_chnl.sv | 23 ++
 rtl/a2d_scan_avg.sv | 185 ++++++++++++++++++
 tb/tb_a2d_scan_avg.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/a2d_pkg.sv
// Shared types and constants for the A2D scan/average block.
package a2d_pkg;

    localparam int unsigned NUM_CH    = 8;
    localparam int unsigned CH_W      = 3;
    localparam int unsigned RES_W     = 12;
    localparam int unsigned AVG_N     = 4;
    localparam int unsigned AVG_SHIFT = 2;
    localparam int unsigned ACC_W     = RES_W + AVG_SHIFT;
    localparam int unsigned CNT_W     = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        STORE = 2'd3
    } state_e;

    // Lowest channel whose mask bit is set (0 when the mask is empty).
    function automatic logic [CH_W-1:0] lowest_ch(input logic [NUM_CH-1:0] mask);
        logic [CH_W-1:0] ch;
        logic            found;
        ch    = '0;
        found = 1'b0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (!found && mask[i]) begin
                ch    = CH_W'(i);
                found = 1'b1;
            end
        end
        return ch;
    endfunction

endpackage

// File: rtl/a2d_nxt_chnl.sv
// Next enabled channel above cur_i; wraps to the lowest enabled channel and flags it.
module a2d_nxt_chnl
    import a2d_pkg::*;
(
    input  logic [NUM_CH-1:0] mask_i,
    input  logic [CH_W-1:0]   cur_i,
    output logic [CH_W-1:0]   nxt_ch_c_o,
    output logic              wrap_c_o
);

    // Descending scan so the nearest enabled channel above cur_i wins.
    always_comb begin
        nxt_ch_c_o = lowest_ch(mask_i);
        wrap_c_o   = 1'b1;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (mask_i[i] && (CH_W'(i) > cur_i)) begin
                nxt_ch_c_o = CH_W'(i);
                wrap_c_o   = 1'b0;
            end
        end
    end

endmodule

// File: rtl/a2d_scan_avg.sv
// Round-robin A2D channel scanner with a per-channel result register file.
// Define A2D_SCAN_AVG_EN to average 4 samples per channel; otherwise one sample is stored.
module a2d_scan_avg
    import a2d_pkg::*;
#(
    parameter logic [NUM_CH-1:0] CH_MASK     = 8'hFF,
    parameter int unsigned       TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             strt_cnv,
    output logic [CH_W-1:0]  chnnl,
    input  logic             cnv_cmplt,
    input  logic [RES_W-1:0] res,
    input  logic [CH_W-1:0]  rd_chnl,
    output logic [RES_W-1:0] rd_data,
    output logic [NUM_CH-1:0] vld,
    output logic             scan_done,
    output logic             tmo_err
);

    localparam int unsigned     TMO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    state_e             state_q, state_d;
    logic [CH_W-1:0]    chnnl_q, chnnl_d;
    logic               strt_q, strt_d;
    logic               done_q, done_d;
    logic               tmo_err_q, tmo_err_d;
    logic [NUM_CH-1:0]  vld_q, vld_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic               cmplt_prev_q;
    logic [RES_W-1:0]   res_q [NUM_CH];
    logic               wr_en;
    logic [RES_W-1:0]   wr_data;
    logic               adv;
    logic               cmplt_rise;
    logic [CH_W-1:0]    nxt_ch;
    logic               wrap;
`ifdef A2D_SCAN_AVG_EN
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   smp_cnt_q, smp_cnt_d;
`endif

    a2d_nxt_chnl u_nxt (
        .mask_i     (CH_MASK),
        .cur_i      (chnnl_q),
        .nxt_ch_c_o (nxt_ch),
        .wrap_c_o   (wrap)
    );

    // Completion is the rising edge only, so a level left high by the previous conversion is ignored.
    assign cmplt_rise = cnv_cmplt & ~cmplt_prev_q;

    always_comb begin
        state_d   = state_q;
        chnnl_d   = chnnl_q;
        tmo_err_d = tmo_err_q;
        vld_d     = vld_q;
        tmo_cnt_d = tmo_cnt_q;
        done_d    = 1'b0;
        wr_en     = 1'b0;
        wr_data   = '0;
        adv       = 1'b0;
`ifdef A2D_SCAN_AVG_EN
        acc_d     = acc_q;
        smp_cnt_d = smp_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (en && (CH_MASK != '0)) begin
                    chnnl_d = lowest_ch(CH_MASK);
                    state_d = START;
                end
            end
            START: begin
                tmo_cnt_d = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                if (cmplt_rise) begin
`ifdef A2D_SCAN_AVG_EN
                    acc_d     = acc_q + ACC_W'(res);
                    smp_cnt_d = smp_cnt_q + 1'b1;
`else
                    wr_en          = 1'b1;
                    wr_data        = res;
                    vld_d[chnnl_q] = 1'b1;
`endif
                    state_d = STORE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    // Abandon this channel: its partial average is meaningless.
                    tmo_err_d = 1'b1;
`ifdef A2D_SCAN_AVG_EN
                    acc_d     = '0;
                    smp_cnt_d = '0;
`endif
                    adv       = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            STORE: begin
`ifdef A2D_SCAN_AVG_EN
                if (smp_cnt_q < CNT_W'(AVG_N)) begin
                    state_d = START;
                end else begin
                    wr_en          = 1'b1;
                    wr_data        = acc_q[ACC_W-1:AVG_SHIFT];
                    vld_d[chnnl_q] = 1'b1;
                    acc_d          = '0;
                    smp_cnt_d      = '0;
                    adv            = 1'b1;
                end
`else
                adv = 1'b1;
`endif
            end
            default: state_d = IDLE;
        endcase

        // Channel advance; en is only honoured at the end of a full pass.
        if (adv) begin
            chnnl_d = nxt_ch;
            if (wrap) begin
                done_d  = 1'b1;
                state_d = en ? START : IDLE;
            end else begin
                state_d = START;
            end
        end

        strt_d = (state_d == START);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            chnnl_q      <= '0;
            strt_q       <= 1'b0;
            done_q       <= 1'b0;
            tmo_err_q    <= 1'b0;
            vld_q        <= '0;
            tmo_cnt_q    <= '0;
            cmplt_prev_q <= 1'b0;
`ifdef A2D_SCAN_AVG_EN
            acc_q        <= '0;
            smp_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            chnnl_q      <= chnnl_d;
            strt_q       <= strt_d;
            done_q       <= done_d;
            tmo_err_q    <= tmo_err_d;
            vld_q        <= vld_d;
            tmo_cnt_q    <= tmo_cnt_d;
            cmplt_prev_q <= cnv_cmplt;
`ifdef A2D_SCAN_AVG_EN
            acc_q        <= acc_d;
            smp_cnt_q    <= smp_cnt_d;
`endif
        end
    end

    // Result file; a same-cycle read of the written channel still sees the old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                res_q[i] <= '0;
            end
        end else if (wr_en) begin
            res_q[chnnl_q] <= wr_data;
        end
    end

    assign rd_data   = res_q[rd_chnl];
    assign strt_cnv  = strt_q;
    assign chnnl     = chnnl_q;
    assign vld       = vld_q;
    assign scan_done = done_q;
    assign tmo_err   = tmo_err_q;

endmodule

// File: tb/tb_a2d_scan_avg.sv
// Directed bench for a2d_scan_avg: three instances (masks 05, 06, 08) driven by a simple A2D model.
module tb_a2d_scan_avg;

`ifdef A2D_SCAN_AVG_EN
    localparam int NS = 4;
`else
    localparam int NS = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en     [3];
    logic [2:0]  rd_ch  [3];
    logic        strt   [3];
    logic [2:0]  chnnl  [3];
    logic [11:0] rd_data[3];
    logic [7:0]  vld    [3];
    logic        sdone  [3];
    logic        tmo    [3];
    logic        cmplt  [3] = '{default: 1'b0};
    logic [11:0] res    [3] = '{default: 12'h000};

    // Model configuration (written only by the stimulus block)
    int          lat     [3];
    int          hold_hi [3];
    int          never_ch[3];
    logic [11:0] val_tab [3][8][4];

    // Model state (written only by the model)
    int          mdl_phase[3]    = '{default: 0};
    int          mdl_cnt  [3]    = '{default: 0};
    logic [11:0] nxt_val  [3]    = '{default: 12'h000};
    int          smp_idx  [3][8] = '{default: '{default: 0}};

    // Monitors (written only by the monitor)
    int          strt_cnt[3][8] = '{default: '{default: 0}};
    int          done_cnt[3]    = '{default: 0};

    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    a2d_scan_avg #(.CH_MASK(8'h05), .TIMEOUT_CYC(16)) u_a (
        .clk(clk), .rst(rst), .en(en[0]), .strt_cnv(strt[0]), .chnnl(chnnl[0]),
        .cnv_cmplt(cmplt[0]), .res(res[0]), .rd_chnl(rd_ch[0]), .rd_data(rd_data[0]),
        .vld(vld[0]), .scan_done(sdone[0]), .tmo_err(tmo[0]));

    a2d_scan_avg #(.CH_MASK(8'h06), .TIMEOUT_CYC(16)) u_b (
        .clk(clk), .rst(rst), .en(en[1]), .strt_cnv(strt[1]), .chnnl(chnnl[1]),
        .cnv_cmplt(cmplt[1]), .res(res[1]), .rd_chnl(rd_ch[1]), .rd_data(rd_data[1]),
        .vld(vld[1]), .scan_done(sdone[1]), .tmo_err(tmo[1]));

    a2d_scan_avg #(.CH_MASK(8'h08)) u_c (
        .clk(clk), .rst(rst), .en(en[2]), .strt_cnv(strt[2]), .chnnl(chnnl[2]),
        .cnv_cmplt(cmplt[2]), .res(res[2]), .rd_chnl(rd_ch[2]), .rd_data(rd_data[2]),
        .vld(vld[2]), .scan_done(sdone[2]), .tmo_err(tmo[2]));

    // A2D model: optionally keeps the old completion level high, then low for lat cycles, then rises.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (strt[k]) begin
                if (int'(chnnl[k]) == never_ch[k]) begin
                    cmplt[k]     = 1'b0;
                    mdl_phase[k] = 0;
                end else begin
                    nxt_val[k] = val_tab[k][chnnl[k]][smp_idx[k][chnnl[k]]];
                    smp_idx[k][chnnl[k]] = (smp_idx[k][chnnl[k]] + 1) % 4;
                    if (cmplt[k] && hold_hi[k] > 0) begin
                        mdl_phase[k] = 1;
                        mdl_cnt[k]   = hold_hi[k];
                    end else begin
                        cmplt[k]     = 1'b0;
                        mdl_phase[k] = 2;
                        mdl_cnt[k]   = lat[k];
                    end
                end
            end else if (mdl_phase[k] == 1) begin
                mdl_cnt[k] = mdl_cnt[k] - 1;
                if (mdl_cnt[k] == 0) begin
                    cmplt[k]     = 1'b0;
                    mdl_phase[k] = 2;
                    mdl_cnt[k]   = lat[k];
                end
            end else if (mdl_phase[k] == 2) begin
                mdl_cnt[k] = mdl_cnt[k] - 1;
                if (mdl_cnt[k] == 0) begin
                    cmplt[k]     = 1'b1;
                    res[k]       = nxt_val[k];
                    mdl_phase[k] = 0;
                end
            end
        end
    end

    // Count conversion requests per channel and scan_done high cycles.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (strt[k]) strt_cnt[k][chnnl[k]] <= strt_cnt[k][chnnl[k]] + 1;
            if (sdone[k]) done_cnt[k] <= done_cnt[k] + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input int k, input logic [2:0] ch, output logic [11:0] d);
        rd_ch[k] = ch;
        #1;
        d = rd_data[k];
    endtask

    task automatic wait_done(input int k, input int budget, input string tag);
        int n;
        n = 0;
        while (!sdone[k] && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(sdone[k]), 32'd1);
    endtask

    task automatic wait_strt(input int k, input int ch, input int target, input int budget,
                             input string tag);
        int n;
        n = 0;
        while (strt_cnt[k][ch] < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(strt_cnt[k][ch] >= target), 32'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        logic [11:0] d;
        int          base0, base2, dbase, n;

        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            en[k] = 1'b0; rd_ch[k] = 3'd0; lat[k] = 4; hold_hi[k] = 0; never_ch[k] = -1;
            for (int c = 0; c < 8; c++)
                for (int s = 0; s < 4; s++) val_tab[k][c][s] = 12'h000;
        end
        idle(3);

        // Reset state
        chk("rst_strt", 32'(strt[0]), 32'd0);
        chk("rst_chnnl", 32'(chnnl[0]), 32'd0);
        chk("rst_vld", 32'(vld[0]), 32'd0);
        chk("rst_tmo", 32'(tmo[1]), 32'd0);
        chk("rst_done", 32'(sdone[2]), 32'd0);
        rst = 1'b0;
        idle(2);

        // Pass 1 on mask 05: one full scan, en released early so it stops at the wrap
        val_tab[0][0][0] = 12'h100; val_tab[0][0][1] = 12'h104;
        val_tab[0][0][2] = 12'h108; val_tab[0][0][3] = 12'h10C;
        val_tab[0][2][0] = (NS == 4) ? 12'hFFF : 12'hABC;
        val_tab[0][2][1] = 12'hFFF; val_tab[0][2][2] = 12'hFFF; val_tab[0][2][3] = 12'hFFF;
        dbase = done_cnt[0];
        en[0] = 1'b1;
        idle(3);
        en[0] = 1'b0;
        wait_done(0, 400, "p1_scan_done");
        rd(0, 3'd0, d);
        chk("p1_rd_ch0", 32'(d), (NS == 4) ? 32'h106 : 32'h100);
        rd(0, 3'd2, d);
        chk("p1_rd_ch2", 32'(d), (NS == 4) ? 32'hFFF : 32'hABC);
        chk("p1_vld", 32'(vld[0]), 32'h05);
        idle(10);
        chk("p1_done_once", 32'(done_cnt[0] - dbase), 32'd1);
        chk("p1_strt_ch0", 32'(strt_cnt[0][0]), 32'(NS));
        chk("p1_strt_ch2", 32'(strt_cnt[0][2]), 32'(NS));
        chk("p1_idle_strt", 32'(strt[0]), 32'd0);

        // Pass 2: cnv_cmplt still high from pass 1 at every START
        val_tab[0][0][0] = 12'h200; val_tab[0][0][1] = 12'h210;
        val_tab[0][0][2] = 12'h220; val_tab[0][0][3] = 12'h230;
        for (int s = 0; s < 4; s++) val_tab[0][2][s] = 12'h300;
        hold_hi[0] = 3;
        base0 = strt_cnt[0][0];
        base2 = strt_cnt[0][2];
        chk("p2_stale_level", 32'(cmplt[0]), 32'd1);
        en[0] = 1'b1;
        idle(2);
        en[0] = 1'b0;
        wait_done(0, 600, "p2_scan_done");
        rd(0, 3'd0, d);
        chk("p2_rd_ch0", 32'(d), (NS == 4) ? 32'h218 : 32'h210);
        rd(0, 3'd2, d);
        chk("p2_rd_ch2", 32'(d), 32'h300);
        idle(10);
        chk("p2_strt_ch0", 32'(strt_cnt[0][0] - base0), 32'(NS));
        chk("p2_strt_ch2", 32'(strt_cnt[0][2] - base2), 32'(NS));

        // Reset while waiting on the 3rd sample of ch0; the late completion must be ignored
        hold_hi[0] = 0;
        lat[0]     = 4;
        base0 = strt_cnt[0][0];
        en[0] = 1'b1;
        wait_strt(0, 0, base0 + ((NS == 4) ? 3 : 1), 200, "r_reach_wait");
        rst   = 1'b1;
        en[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("r_strt", 32'(strt[0]), 32'd0);
        chk("r_chnnl", 32'(chnnl[0]), 32'd0);
        chk("r_done", 32'(sdone[0]), 32'd0);
        chk("r_tmo", 32'(tmo[0]), 32'd0);
        chk("r_vld", 32'(vld[0]), 32'h00);
        rd(0, 3'd0, d);
        chk("r_rd_ch0", 32'(d), 32'h000);
        base0 = strt_cnt[0][0];
        idle(12);
        chk("r_late_cmplt_seen", 32'(cmplt[0]), 32'd1);
        chk("r_no_restart", 32'(strt_cnt[0][0] - base0), 32'd0);
        chk("r_vld_after", 32'(vld[0]), 32'h00);
        rd(0, 3'd0, d);
        chk("r_rd_after", 32'(d), 32'h000);

        // Timeout on ch1 (mask 06, TIMEOUT_CYC=16), scan continues on ch2
        never_ch[1] = 1;
        lat[1]      = 3;
        val_tab[1][2][0] = 12'h010; val_tab[1][2][1] = 12'h020;
        val_tab[1][2][2] = 12'h030; val_tab[1][2][3] = 12'h040;
        en[1] = 1'b1;
        wait_strt(1, 1, 1, 50, "t_strt_ch1");
        idle(1);
        en[1] = 1'b0;
        n = 1;
        while (!tmo[1] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t_wait_cycles", 32'(n), 32'd16);
        chk("t_next_chnnl", 32'(chnnl[1]), 32'd2);
        chk("t_next_strt", 32'(strt[1]), 32'd1);
        chk("t_vld_mid", 32'(vld[1]), 32'h00);
        wait_done(1, 400, "t_scan_done");
        chk("t_vld", 32'(vld[1]), 32'h04);
        chk("t_tmo_sticky", 32'(tmo[1]), 32'd1);
        rd(1, 3'd1, d);
        chk("t_rd_ch1", 32'(d), 32'h000);
        rd(1, 3'd2, d);
        chk("t_rd_ch2", 32'(d), (NS == 4) ? 32'h028 : 32'h010);

        // en dropped during the 2nd sample of ch3 (mask 08)
        lat[2] = 3;
        val_tab[2][3][0] = 12'h7FF; val_tab[2][3][1] = 12'h801;
        val_tab[2][3][2] = 12'h7FF; val_tab[2][3][3] = 12'h801;
        dbase = done_cnt[2];
        en[2] = 1'b1;
        wait_strt(2, 3, (NS == 4) ? 2 : 1, 100, "e_reach_2nd");
        en[2] = 1'b0;
        wait_done(2, 200, "e_scan_done");
        rd(2, 3'd3, d);
        chk("e_rd_ch3", 32'(d), (NS == 4) ? 32'h800 : 32'h7FF);
        chk("e_vld", 32'(vld[2]), 32'h08);
        idle(20);
        chk("e_strt_total", 32'(strt_cnt[2][3]), 32'(NS));
        chk("e_done_once", 32'(done_cnt[2] - dbase), 32'd1);
        chk("e_idle_strt", 32'(strt[2]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
